// File: rtl/pc_out_s2p_if.sv
// Array-side and memory-side signals of the output port controller.
// The environment drives through master; the controller sits on slave.
interface pc_out_s2p_if #(
  parameter int WIDTH_ARR = 16,
  parameter int WIDTH_BUS = 64
);
  logic                 start;
  logic [55:0]          config_bits;
  logic [WIDTH_ARR-1:0] wr_data_arr2pc;
  logic                 wr_data_arr2pc_en;
  logic                 rdy_pc2arr;
  logic                 tk_en;
  logic                 wr_req_en;
  logic [33:0]          wr_req_out;
  logic [WIDTH_BUS-1:0] wr_data_pc2mem;
  logic                 busy;
  logic                 done;

  modport master (
    output start, config_bits, wr_data_arr2pc, wr_data_arr2pc_en, tk_en,
    input  rdy_pc2arr, wr_req_en, wr_req_out, wr_data_pc2mem, busy, done
  );

  modport slave (
    input  start, config_bits, wr_data_arr2pc, wr_data_arr2pc_en, tk_en,
    output rdy_pc2arr, wr_req_en, wr_req_out, wr_data_pc2mem, busy, done
  );
endinterface

// File: rtl/pc_out_s2p.sv
// Output port controller: packs array result words MSB-first into bus words,
// buffers {addr,data} in a small FIFO and issues one write per bus grant.
module pc_out_s2p #(
  parameter int          WIDTH_ARR  = 16,
  parameter int          WIDTH_BUS  = 64,
  parameter logic [5:0]  P_ID       = 6'd0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk_bus,
  input  logic         rst_bus,
  pc_out_s2p_if.slave  bus
);
  localparam int P2S_FACT = WIDTH_BUS / WIDTH_ARR;
  localparam int PW       = (P2S_FACT > 1) ? $clog2(P2S_FACT) : 1;
  localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW       = 28 + WIDTH_BUS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_pack_cnt;
  logic [27:0]          r_word_cnt;
  logic [27:0]          r_base;
  logic [27:0]          r_offset;
  logic [WIDTH_BUS-1:0] r_pack;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;
  logic                 r_req_en;
  logic [33:0]          r_req_out;
  logic [WIDTH_BUS-1:0] r_req_data;
  logic                 r_done;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_last_slot;
  logic                 w_rdy;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [27:0]          w_addr;
  logic [WIDTH_BUS-1:0] w_packed;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_last_slot = (r_pack_cnt == PW'(P2S_FACT - 1));
  // Only the group-completing word needs FIFO room; the registered full flag
  // is used so a same-cycle pop never enables a push into a full FIFO.
  assign w_rdy       = (r_state == S_RUN) && !(w_full && w_last_slot);
  assign w_accept    = bus.wr_data_arr2pc_en && w_rdy;
  assign w_push      = w_accept && w_last_slot;
  assign w_pop       = bus.tk_en && !w_empty;
  assign w_addr      = r_base + r_word_cnt;
  assign w_packed    = (r_pack << WIDTH_ARR) | WIDTH_BUS'(bus.wr_data_arr2pc);

  assign bus.rdy_pc2arr     = w_rdy;
  assign bus.wr_req_en      = r_req_en;
  assign bus.wr_req_out     = r_req_out;
  assign bus.wr_data_pc2mem = r_req_data;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;

  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      r_state    <= S_IDLE;
      r_pack_cnt <= '0;
      r_word_cnt <= '0;
      r_base     <= '0;
      r_offset   <= '0;
      r_pack     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_req_en   <= 1'b0;
      r_req_out  <= '0;
      r_req_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_req_en   <= w_pop;
      r_req_out  <= w_pop ? {P_ID, r_mem[r_rptr][EW-1:WIDTH_BUS]} : '0;
      r_req_data <= w_pop ? r_mem[r_rptr][WIDTH_BUS-1:0] : '0;

      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push) begin
        r_mem[r_wptr] <= {w_addr, w_packed};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);

      if (w_accept) begin
        r_pack <= w_packed;
        if (w_last_slot) begin
          r_pack_cnt <= '0;
          r_word_cnt <= r_word_cnt + 28'd1;
        end else begin
          r_pack_cnt <= r_pack_cnt + PW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base     <= bus.config_bits[55:28];
            r_offset   <= bus.config_bits[27:0];
            r_pack_cnt <= '0;
            r_word_cnt <= '0;
            r_pack     <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_push && (r_word_cnt == r_offset)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // r_req_en covers the write still on the bus from the final pop.
          if (w_empty && !r_req_en) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
